if_fetch_stage: RTL and testbench



---
 rtl/if_fetch_stage_pkg.sv | 35 +++
 rtl/if_fetch_stage_if.sv | 31 +++
 rtl/if_next_pc.sv | 45 ++++
 rtl/if_fetch_stage.sv | 126 ++++++++++++
 tb/tb_if_fetch_stage.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_stage_pkg.sv
// ============================================================================
// if_fetch_stage_pkg : shared types and constants for the instruction-fetch stage
// Rev 1.0
// ============================================================================
`default_nettype none

package if_fetch_stage_pkg;

  localparam int PC_W = 30;

  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 30'h2FF00000;
  localparam logic [PC_W-1:0] EXC_PC_DEFAULT   = 30'h2FF000E0;
  localparam logic [PC_W-1:0] PC_ONE           = 30'd1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_RSP = 2'd1,
    ST_FULL     = 2'd2
  } fetch_state_t;

  typedef enum logic [1:0] {
    NPC_HOLD     = 2'd0,
    NPC_SEQ      = 2'd1,
    NPC_REDIRECT = 2'd2,
    NPC_EXC      = 2'd3
  } npc_sel_t;

  // Word-address increment; wraps modulo 2^30.
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + PC_ONE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/if_fetch_stage_if.sv
// ============================================================================
// if_fetch_stage_if : single-outstanding instruction-memory request bus
// Rev 1.0
// ============================================================================
`default_nettype none

interface if_fetch_stage_if;
  import if_fetch_stage_pkg::*;

  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

`default_nettype wire

// File: rtl/if_next_pc.sv
// ============================================================================
// if_next_pc : combinational next-PC select (exception / redirect / +1 / hold)
// Rev 1.0
// ============================================================================
`default_nettype none

module if_next_pc
  import if_fetch_stage_pkg::*;
#(
  parameter logic [PC_W-1:0] EXC_PC = EXC_PC_DEFAULT
) (
  input  logic [PC_W-1:0] pc,
  input  logic            exc,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            advance,
  output logic [PC_W-1:0] next_pc
);

  npc_sel_t w_sel;

  always_comb begin
    w_sel = NPC_HOLD;
    if (exc) begin
      w_sel = NPC_EXC;
    end else if (redirect) begin
      w_sel = NPC_REDIRECT;
    end else if (advance) begin
      w_sel = NPC_SEQ;
    end
  end

  always_comb begin
    next_pc = pc;
    unique case (w_sel)
      NPC_EXC:      next_pc = EXC_PC;
      NPC_REDIRECT: next_pc = redirect_pc;
      NPC_SEQ:      next_pc = pc_inc(pc);
      default:      next_pc = pc;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/if_fetch_stage.sv
// ============================================================================
// if_fetch_stage : PC owner, imem requester and one-entry IF/ID output buffer
// Rev 1.0
// ============================================================================
`default_nettype none

module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [PC_W-1:0] EXC_PC   = EXC_PC_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ID_Ready,
  input  logic             Redirect,
  input  logic [PC_W-1:0]  Redirect_Pc,
  input  logic             Exc,
  if_fetch_stage_if.master imem,
  output logic [31:0]      IF_IrOut,
  output logic [PC_W-1:0]  IF_PcAddOne,
  output logic             IF_Valid
);

  fetch_state_t    r_state;
  logic [PC_W-1:0] r_pc;
  logic            r_kill;
  logic            r_req;
  logic [PC_W-1:0] r_addr;
  logic [31:0]     r_ir;
  logic [PC_W-1:0] r_pc_add_one;
  logic            r_valid;

  logic            w_flush;
  logic            w_advance;
  logic [PC_W-1:0] w_next_pc;

  assign w_flush   = Exc | Redirect;
  assign w_advance = (r_state == ST_FULL) && ID_Ready;

  if_next_pc #(
    .EXC_PC (EXC_PC)
  ) u_next_pc (
    .pc          (r_pc),
    .exc         (Exc),
    .redirect    (Redirect),
    .redirect_pc (Redirect_Pc),
    .advance     (w_advance),
    .next_pc     (w_next_pc)
  );

  // pc follows the next-PC selector every cycle; in WAIT_RSP without a
  // flush the selector holds, so the address under request stays put.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_pc         <= RESET_PC;
      r_kill       <= 1'b0;
      r_req        <= 1'b0;
      r_addr       <= '0;
      r_ir         <= '0;
      r_pc_add_one <= '0;
      r_valid      <= 1'b0;
    end else begin
      r_pc <= w_next_pc;
      case (r_state)
        ST_IDLE: begin
          r_req   <= 1'b1;
          r_addr  <= w_next_pc;
          r_state <= ST_WAIT_RSP;
        end

        ST_WAIT_RSP: begin
          if (w_flush) begin
            if (imem.imem_rvalid) begin
              r_kill <= 1'b0;
              r_addr <= w_next_pc;
            end else begin
              // Request cannot be withdrawn; mark its response as stale.
              r_kill <= 1'b1;
            end
          end else if (imem.imem_rvalid) begin
            if (r_kill) begin
              r_kill <= 1'b0;
              r_addr <= r_pc;
            end else begin
              r_ir         <= imem.imem_rdata;
              r_pc_add_one <= pc_inc(r_pc);
              r_valid      <= 1'b1;
              r_req        <= 1'b0;
              r_state      <= ST_FULL;
            end
          end
        end

        ST_FULL: begin
          if (w_flush || ID_Ready) begin
            r_valid <= 1'b0;
            r_req   <= 1'b1;
            r_addr  <= w_next_pc;
            r_state <= ST_WAIT_RSP;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign imem.imem_req  = r_req;
  assign imem.imem_addr = r_addr;
  assign IF_IrOut       = r_ir;
  assign IF_PcAddOne    = r_pc_add_one;
  assign IF_Valid       = r_valid;

  a_addr_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (r_req && !imem.imem_rvalid) |=> (r_req && $stable(r_addr)));

  a_valid_full: assert property (@(posedge clk) disable iff (!rst_n)
    r_valid == (r_state == ST_FULL));

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
// ============================================================================
// tb_if_fetch_stage : directed self-checking bench for if_fetch_stage
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_if_fetch_stage;
  import if_fetch_stage_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            ID_Ready = 1'b0;
  logic            Redirect = 1'b0;
  logic [PC_W-1:0] Redirect_Pc = '0;
  logic            Exc = 1'b0;
  logic [31:0]     IF_IrOut;
  logic [PC_W-1:0] IF_PcAddOne;
  logic            IF_Valid;

  if_fetch_stage_if bus ();

  if_fetch_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ID_Ready    (ID_Ready),
    .Redirect    (Redirect),
    .Redirect_Pc (Redirect_Pc),
    .Exc         (Exc),
    .imem        (bus.master),
    .IF_IrOut    (IF_IrOut),
    .IF_PcAddOne (IF_PcAddOne),
    .IF_Valid    (IF_Valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory model: response word is {addr, 2'b01}; latency counted in cycles.
  logic            mem_en = 1'b0;
  int              mem_lat = 1;
  logic            mem_busy = 1'b0;
  int              mem_cnt = 0;
  logic [PC_W-1:0] mem_addr = '0;
  logic            m_rvalid = 1'b0;
  logic [31:0]     m_rdata = '0;
  logic            f_rvalid = 1'b0;
  logic [31:0]     f_rdata = '0;
  logic [PC_W-1:0] req_log [$];

  assign bus.imem_rvalid = m_rvalid | f_rvalid;
  assign bus.imem_rdata  = f_rvalid ? f_rdata : m_rdata;

  always @(negedge clk) begin
    if (!mem_en) begin
      m_rvalid = 1'b0;
      mem_busy = 1'b0;
    end else if (m_rvalid) begin
      m_rvalid = 1'b0;
      mem_busy = 1'b0;
    end else if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        m_rvalid = 1'b1;
        m_rdata  = {mem_addr, 2'b01};
      end
    end
    if (mem_en && !mem_busy && bus.imem_req) begin
      mem_busy = 1'b1;
      mem_addr = bus.imem_addr;
      mem_cnt  = mem_lat;
      req_log.push_back(bus.imem_addr);
    end
  end

  task automatic wait_valid(input string tag, input int max);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (IF_Valid) begin
        seen = 1'b1;
        break;
      end
    end
    check_val({tag, " valid_seen"}, {31'd0, seen}, 32'd1);
  endtask

  task automatic check_log(input int idx, input logic [PC_W-1:0] exp);
    logic [PC_W-1:0] got;
    got = (idx < req_log.size()) ? req_log[idx] : '1;
    check_val($sformatf("req_addr[%0d]", idx), {2'b00, got}, {2'b00, exp});
  endtask

  initial begin
    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check_val("rst imem_req",    {31'd0, bus.imem_req}, 32'd0);
    check_val("rst imem_addr",   {2'b00, bus.imem_addr}, 32'd0);
    check_val("rst IF_IrOut",    IF_IrOut, 32'd0);
    check_val("rst IF_PcAddOne", {2'b00, IF_PcAddOne}, 32'd0);
    check_val("rst IF_Valid",    {31'd0, IF_Valid}, 32'd0);
    mem_en   = 1'b1;
    mem_lat  = 1;
    ID_Ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Streaming with latency 1 and ID_Ready high
    wait_valid("t1a", 10);
    check_val("t1a ir",  IF_IrOut, 32'hBFC00001);
    check_val("t1a pc1", {2'b00, IF_PcAddOne}, 32'h2FF00001);
    wait_valid("t1b", 10);
    check_val("t1b ir",  IF_IrOut, 32'hBFC00005);
    check_val("t1b pc1", {2'b00, IF_PcAddOne}, 32'h2FF00002);
    wait_valid("t1c", 10);
    check_val("t1c ir",  IF_IrOut, 32'hBFC00009);
    check_val("t1c pc1", {2'b00, IF_PcAddOne}, 32'h2FF00003);
    check_log(0, 30'h2FF00000);
    check_log(1, 30'h2FF00001);
    check_log(2, 30'h2FF00002);

    // Stall while FULL
    @(negedge clk);
    ID_Ready = 1'b0;
    wait_valid("t2", 10);
    for (int i = 0; i < 5; i++) begin
      check_val("t2 hold valid", {31'd0, IF_Valid}, 32'd1);
      check_val("t2 hold ir",    IF_IrOut, 32'hBFC0000D);
      check_val("t2 hold pc1",   {2'b00, IF_PcAddOne}, 32'h2FF00004);
      check_val("t2 hold req",   {31'd0, bus.imem_req}, 32'd0);
      @(negedge clk);
    end

    // Redirect during WAIT_RSP with latency 3
    mem_lat  = 3;
    ID_Ready = 1'b1;
    @(negedge clk);
    ID_Ready    = 1'b0;
    Redirect    = 1'b1;
    Redirect_Pc = 30'h00000100;
    @(negedge clk);
    Redirect = 1'b0;
    check_val("t3 addr kept", {2'b00, bus.imem_addr}, 32'h2FF00004);
    check_val("t3 req held",  {31'd0, bus.imem_req}, 32'd1);
    wait_valid("t3", 20);
    check_val("t3 ir",  IF_IrOut, 32'h00000401);
    check_val("t3 pc1", {2'b00, IF_PcAddOne}, 32'h00000101);
    check_log(3, 30'h2FF00003);
    check_log(4, 30'h2FF00004);
    check_log(5, 30'h00000100);

    // Redirect and Exc together while FULL: exception wins
    mem_lat     = 1;
    Redirect    = 1'b1;
    Exc         = 1'b1;
    Redirect_Pc = 30'h00000200;
    @(negedge clk);
    Redirect = 1'b0;
    Exc      = 1'b0;
    check_val("t4 valid drop", {31'd0, IF_Valid}, 32'd0);
    check_val("t4 req",        {31'd0, bus.imem_req}, 32'd1);
    check_val("t4 addr",       {2'b00, bus.imem_addr}, 32'h2FF000E0);
    wait_valid("t4", 10);
    check_val("t4 ir",  IF_IrOut, 32'hBFC00381);
    check_val("t4 pc1", {2'b00, IF_PcAddOne}, 32'h2FF000E1);

    // Redirect coinciding with the response
    mem_lat  = 2;
    ID_Ready = 1'b1;
    @(negedge clk);
    ID_Ready = 1'b0;
    begin
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        #1;
        if (bus.imem_rvalid) begin
          hit = 1'b1;
          break;
        end
      end
      check_val("t5 rvalid seen", {31'd0, hit}, 32'd1);
    end
    Redirect    = 1'b1;
    Redirect_Pc = 30'h00000300;
    @(negedge clk);
    Redirect = 1'b0;
    check_val("t5 valid", {31'd0, IF_Valid}, 32'd0);
    check_val("t5 req",   {31'd0, bus.imem_req}, 32'd1);
    check_val("t5 addr",  {2'b00, bus.imem_addr}, 32'h00000300);
    wait_valid("t5", 10);
    check_val("t5 ir",  IF_IrOut, 32'h00000C01);
    check_val("t5 pc1", {2'b00, IF_PcAddOne}, 32'h00000301);
    check_log(6, 30'h2FF000E0);
    check_log(7, 30'h2FF000E1);
    check_log(8, 30'h00000300);
    check_val("t5 req count", req_log.size(), 32'd9);

    // Async reset during WAIT_RSP, then a late response while IDLE
    mem_lat  = 3;
    ID_Ready = 1'b1;
    @(negedge clk);
    ID_Ready = 1'b0;
    #2;
    rst_n  = 1'b0;
    mem_en = 1'b0;
    #1;
    check_val("t6 rst req",  {31'd0, bus.imem_req}, 32'd0);
    check_val("t6 rst addr", {2'b00, bus.imem_addr}, 32'd0);
    check_val("t6 rst ir",   IF_IrOut, 32'd0);
    check_val("t6 rst pc1",  {2'b00, IF_PcAddOne}, 32'd0);
    check_val("t6 rst vld",  {31'd0, IF_Valid}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    f_rdata  = 32'hDEADBEEF;
    f_rvalid = 1'b1;
    mem_en   = 1'b1;
    @(negedge clk);
    f_rvalid = 1'b0;
    check_val("t6 idle vld",  {31'd0, IF_Valid}, 32'd0);
    check_val("t6 idle req",  {31'd0, bus.imem_req}, 32'd1);
    check_val("t6 idle addr", {2'b00, bus.imem_addr}, 32'h2FF00000);
    wait_valid("t6", 20);
    check_val("t6 ir",  IF_IrOut, 32'hBFC00001);
    check_val("t6 pc1", {2'b00, IF_PcAddOne}, 32'h2FF00001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
